fifo_dest: RTL and testbench
============================

FIFO_DEST -- requirements
Module: fifo_dest

Interface
- REQ-001 SHALL: parameter BITNUMBER, default 5, data word width.
- REQ-002 SHALL: parameter DEPTH_LOG2, default 3, log2 of FIFO depth; DEPTH = 2^DEPTH_LOG2 = 8.
- REQ-003 SHALL: parameter ALMOST_FULL_TH, default 6, occupancy at or above which almost_full asserts.
- REQ-004 SHALL: parameter ALMOST_EMPTY_TH, default 2, occupancy at or below which almost_empty asserts.
- REQ-005 SHALL: clk  input  1  single clock; all state updates on its rising edge.
- REQ-006 SHALL: reset  input  1  synchronous, active-low reset.
- REQ-007 SHALL: push  input  1  write request; driven by one per-destination valid output of the destination demux.
- REQ-008 SHALL: data_in  input  BITNUMBER  write data; driven by the matching per-destination data output of the destination demux.
- REQ-009 SHALL: pop  input  1  read request from the consumer.
- REQ-010 SHALL: data_out  output  BITNUMBER  registered read data.
- REQ-011 SHALL: valid_out  output  1  registered; high for one cycle per accepted pop.
- REQ-012 SHALL: full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
- REQ-013 SHALL: error  output  1  sticky overflow/underflow flag.

Function
- REQ-014 SHALL: storage of DEPTH entries of BITNUMBER bits, with DEPTH_LOG2-bit write and read pointers that wrap from DEPTH-1 to 0, and a (DEPTH_LOG2+1)-bit occupancy count.
- REQ-015 SHALL: pop accepted when pop=1 and count>0; at the clock edge data_out <= entry[rd_ptr], valid_out <= 1, rd_ptr increments.
- REQ-016 SHALL: push accepted when push=1 and either count<DEPTH or a pop is accepted in the same cycle; at the clock edge entry[wr_ptr] <= data_in and wr_ptr increments.
- REQ-017 SHALL: a push accepted at edge N is poppable from the cycle after edge N; there is no fall-through, so pop with count=0 is rejected even when push=1.
- REQ-018 SHALL: on a cycle with no accepted pop, at the edge valid_out <= 0 and data_out <= 0.
- REQ-019 SHALL: count updates at the edge as follows: +1 for push-only, -1 for pop-only, unchanged for simultaneous accepted push and pop (including at full).
- REQ-020 SHALL: flags are combinational from count: full = (count==DEPTH); empty = (count==0); almost_full = (count>=ALMOST_FULL_TH); almost_empty = (count<=ALMOST_EMPTY_TH).
- REQ-021 SHALL: a rejected push leaves pointers, count and storage unchanged; the data is dropped.
- REQ-022 SHALL: a rejected pop leaves pointers and count unchanged and produces valid_out=0 on the next cycle.
- REQ-023 SHALL: entries are read out in exact write order across pointer wrap-around.

Reset
- REQ-024 SHALL: while reset=0 at a rising edge, set wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0 and error=0; storage contents are not cleared.
- REQ-025 SHALL: reset asserted mid-operation discards all stored entries; after reset empty=1, almost_empty=1, full=0 and almost_full=0.
- REQ-026 SHALL: push and pop are ignored in any cycle where reset=0.

Configuration
- REQ-027 SHALL: with macro FIFO_DEST_ERROR_EN defined, error is set at the edge following a rejected push (count==DEPTH, no accepted pop) or a rejected pop (pop=1, count==0), and stays 1 until reset.
- REQ-028 SHALL: with FIFO_DEST_ERROR_EN undefined, error is a constant 0, no error logic is present, and all other behaviour is identical.

Verification
- REQ-029 SHALL: after reset, push 5'h11, 5'h12, 5'h13 on consecutive cycles, then pop three cycles -> data_out 5'h11, 5'h12, 5'h13 with valid_out=1, one cycle after each pop; empty=1 at end.
- REQ-030 SHALL: push 8 words 0..7 -> almost_full rises when count reaches 6, full rises at 8; a 9th push (5'h1F) is dropped; draining returns 0..7 in order.
- REQ-031 SHALL: at full, push 5'h0A with pop in the same cycle -> count stays 8 and full stays 1; drain order ends with 5'h0A.
- REQ-032 SHALL: with count=0, push=1 and pop=1 in the same cycle -> valid_out=0 on the next cycle, count=1, and the next pop returns the pushed word.
- REQ-033 SHALL: fill to 5 entries, then drive reset=0 for one cycle -> count=0, empty=1, valid_out=0; a subsequent push/pop round-trips 5'h15 correctly.
- REQ-034 SHALL: with FIFO_DEST_ERROR_EN defined, pop while empty -> error=1 on the next cycle and held through 10 further normal cycles until reset; with the macro undefined, error stays 0.

Source files
------------

// File: rtl/fifo_dest.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_dest                                                  |
// | Description : Per-destination synchronous FIFO fed by one output of the  |
// |               destination demux. Registered read data, occupancy flags   |
// |               decoded from the count, optional sticky error flag.        |
// | Ports       : clk          - single clock, rising edge                   |
// |               reset        - synchronous, active-low reset               |
// |               push/data_in - write request and write data                |
// |               pop          - read request from the consumer              |
// |               data_out     - registered read data (0 when no read)       |
// |               valid_out    - registered, one cycle per accepted pop      |
// |               full/empty/almost_full/almost_empty - occupancy flags      |
// |               error        - sticky overflow/underflow flag              |
// | Config      : define FIFO_DEST_ERROR_EN to build the sticky error logic; |
// |               without it, error is tied to 0.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fifo_dest #(
  parameter int BITNUMBER       = 5,
  parameter int DEPTH_LOG2      = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [BITNUMBER-1:0] data_in,
  input  logic                 pop,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 valid_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Count-width versions of the constants so every compare is width-matched.
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] AF_TH     = ALMOST_FULL_TH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AE_TH     = ALMOST_EMPTY_TH[DEPTH_LOG2:0];

  logic [BITNUMBER-1:0]  mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q,  count_d;
  logic [BITNUMBER-1:0]  data_q,   data_d;
  logic                  valid_q,  valid_d;

  logic w_pop_acc;
  logic w_push_acc;

  // Flags are pure decodes of the registered count.
  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);

  // No fall-through: a pop needs an entry already stored. A push into a full
  // FIFO is still taken when the same cycle frees a slot with a pop.
  assign w_pop_acc  = pop && !empty;
  assign w_push_acc = push && (!full || w_pop_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = '0;
    valid_d  = 1'b0;

    if (w_push_acc) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end

    if (w_pop_acc) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      data_d   = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
    end

    case ({w_push_acc, w_pop_acc})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  // Storage is deliberately not cleared by reset; only writes are blocked.
  always_ff @(posedge clk) begin
    if (reset && w_push_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

`ifdef FIFO_DEST_ERROR_EN
  logic error_q, error_d;

  // Rejected push (full, no pop freeing a slot) or pop on an empty FIFO.
  always_comb begin
    error_d = error_q;
    if ((push && !w_push_acc) || (pop && empty)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_dest.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fifo_dest                                               |
// | Description : Self-checking bench for fifo_dest: vector table, directed  |
// |               corner sequences and random traffic against a queue model. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fifo_dest;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [4:0] data_in;
  logic       pop;
  logic [4:0] data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       error;

  fifo_dest dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of stored words plus the expected registered outputs.
  logic [4:0] m_q [$];
  logic [4:0] m_data;
  logic       m_valid;
  logic       m_err;

  typedef struct {
    logic       rst_n;
    logic       push;
    logic [4:0] din;
    logic       pop;
    logic       e_valid;
    logic [4:0] e_data;
    logic       e_empty;
    logic       e_full;
    logic       e_ae;
    logic       e_af;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input logic r, input logic p, input logic [4:0] d, input logic po);
    bit pa, pu;
    reset   = r;
    push    = p;
    data_in = d;
    pop     = po;
    @(posedge clk);
    if (!r) begin
      m_q.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_err   = 1'b0;
    end else begin
      pa = po && (m_q.size() > 0);
      pu = p && ((m_q.size() < 8) || pa);
      if (pa) begin
        m_data  = m_q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_data  = '0;
        m_valid = 1'b0;
      end
      if (pu) m_q.push_back(d);
`ifdef FIFO_DEST_ERROR_EN
      if ((p && !pu) || (po && !pa)) m_err = 1'b1;
`endif
    end
    #1;
    chk("mdl_data_out",  data_out,     m_data);
    chk("mdl_valid_out", valid_out,    m_valid);
    chk("mdl_full",      full,         m_q.size() == 8);
    chk("mdl_empty",     empty,        m_q.size() == 0);
    chk("mdl_almost_full",  almost_full,  m_q.size() >= 6);
    chk("mdl_almost_empty", almost_empty, m_q.size() <= 2);
    chk("mdl_error",     error,        m_err);
  endtask

  initial begin
    reset   = 1'b0;
    push    = 1'b0;
    data_in = '0;
    pop     = 1'b0;
    m_data  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;

    // Three pushes then three pops, from reset.
    tbl[0] = '{1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 5'h11, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 5'h12, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 5'h13, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 5'h00, 1'b1, 1'b1, 5'h11, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 5'h00, 1'b1, 1'b1, 5'h12, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 5'h00, 1'b1, 1'b1, 5'h13, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst_n, tbl[i].push, tbl[i].din, tbl[i].pop);
      chk($sformatf("tbl%0d_valid", i), valid_out,    tbl[i].e_valid);
      chk($sformatf("tbl%0d_data", i),  data_out,     tbl[i].e_data);
      chk($sformatf("tbl%0d_empty", i), empty,        tbl[i].e_empty);
      chk($sformatf("tbl%0d_full", i),  full,         tbl[i].e_full);
      chk($sformatf("tbl%0d_ae", i),    almost_empty, tbl[i].e_ae);
      chk($sformatf("tbl%0d_af", i),    almost_full,  tbl[i].e_af);
    end

    // Fill to full, overflow push dropped, drain in order.
    step(1'b0, 1'b0, 5'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 5'(i), 1'b0);
      chk($sformatf("fill_af_%0d", i), almost_full, (i + 1) >= 6);
      chk($sformatf("fill_full_%0d", i), full, (i + 1) == 8);
    end
    step(1'b1, 1'b1, 5'h1F, 1'b0);
    chk("ovf_full", full, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 5'h00, 1'b1);
      chk($sformatf("drain_%0d", i), data_out, 5'(i));
    end
    chk("drain_empty", empty, 1'b1);

    // Push and pop together while full.
    step(1'b0, 1'b0, 5'h00, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 5'(i + 1), 1'b0);
    step(1'b1, 1'b1, 5'h0A, 1'b1);
    chk("fullpp_data", data_out, 5'h01);
    chk("fullpp_full", full, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 5'h00, 1'b1);
    chk("fullpp_last", data_out, 5'h0A);
    chk("fullpp_empty", empty, 1'b1);

    // Push and pop together while empty: no fall-through.
    step(1'b0, 1'b0, 5'h00, 1'b0);
    step(1'b1, 1'b1, 5'h07, 1'b1);
    chk("emptypp_valid", valid_out, 1'b0);
    chk("emptypp_empty", empty, 1'b0);
    step(1'b1, 1'b0, 5'h00, 1'b1);
    chk("emptypp_valid2", valid_out, 1'b1);
    chk("emptypp_data", data_out, 5'h07);

    // Mid-operation reset discards contents.
    step(1'b0, 1'b0, 5'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 5'(i + 3), 1'b0);
    step(1'b0, 1'b1, 5'h1E, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_ae", almost_empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_valid", valid_out, 1'b0);
    step(1'b1, 1'b1, 5'h15, 1'b0);
    step(1'b1, 1'b0, 5'h00, 1'b1);
    chk("rst_rt_data", data_out, 5'h15);
    chk("rst_rt_empty", empty, 1'b1);

    // Underflow: sticky error when enabled, else constant 0.
    step(1'b0, 1'b0, 5'h00, 1'b0);
    step(1'b1, 1'b0, 5'h00, 1'b1);
`ifdef FIFO_DEST_ERROR_EN
    chk("err_set", error, 1'b1);
`else
    chk("err_set", error, 1'b0);
`endif
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i[0] == 1'b0, 5'(i), i[0] == 1'b1);
`ifdef FIFO_DEST_ERROR_EN
      chk($sformatf("err_hold_%0d", i), error, 1'b1);
`else
      chk($sformatf("err_hold_%0d", i), error, 1'b0);
`endif
    end
    step(1'b0, 1'b0, 5'h00, 1'b0);
    chk("err_clear", error, 1'b0);

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 60) != 0), ($urandom_range(0, 99) < 55),
           5'($urandom), ($urandom_range(0, 99) < 45));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
